// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Adds a blanking gap between digits and only swaps in a new value at a frame boundary.
module seg_scan_ctrl #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 1000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [1:0]  digit_idx,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  timer_r, timer_s;
  logic [1:0]        idx_r, idx_s;
  logic [15:0]       disp_r, disp_s, pend_r, pend_s;
  logic [3:0]        ddp_r, ddp_s, pdp_r, pdp_s;
  logic              pfull_r, pfull_s;
  logic              ready_r;
  logic [3:0]        anode_r, anode_s;
  logic [6:0]        seg_r, seg_s;
  logic              dp_n_r, dp_n_s;
  logic              fstart_r;
  logic              load_s, accept_s;
  logic [3:0]        nib_s;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0010000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      4'hF:    hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  endfunction

  // Scan sequencing: slot timer, digit index and frame-boundary detection.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    idx_s   = idx_r;
    load_s  = 1'b0;
    if (!en) begin
      state_s = IDLE;
      timer_s = '0;
      idx_s   = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = SHOW;
          timer_s = '0;
          idx_s   = 2'd0;
          load_s  = 1'b1;
        end
        SHOW: begin
          if (timer_r == DIGIT_LAST) begin
            state_s = BLANK;
            timer_s = '0;
          end else begin
            timer_s = timer_r + CNT_W'(1);
          end
        end
        BLANK: begin
          if (timer_r == BLANK_LAST) begin
            state_s = SHOW;
            timer_s = '0;
            idx_s   = idx_r + 2'd1;
            load_s  = (idx_r == 2'd3);
          end else begin
            timer_s = timer_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          timer_s = '0;
          idx_s   = 2'd0;
        end
      endcase
    end
  end

  // Pending buffer and display register; a load consumes the old pending contents.
  always_comb begin
    accept_s = value_valid & ready_r;
    disp_s   = disp_r;
    ddp_s    = ddp_r;
    pend_s   = pend_r;
    pdp_s    = pdp_r;
    pfull_s  = pfull_r;
    if (load_s && pfull_r) begin
      disp_s  = pend_r;
      ddp_s   = pdp_r;
      pfull_s = 1'b0;
    end else begin
      disp_s  = disp_r;
      ddp_s   = ddp_r;
    end
    if (accept_s) begin
      pend_s  = value;
      pdp_s   = dp_in;
      pfull_s = 1'b1;
    end else begin
      pend_s  = pend_r;
      pdp_s   = pdp_r;
    end
  end

  // Next output drive, computed from the next state so outputs can be registered.
  always_comb begin
    nib_s  = disp_s[{idx_s, 2'b00} +: 4];
    anode_s = 4'b1111;
    seg_s   = 7'b1111111;
    dp_n_s  = 1'b1;
    if (state_s == SHOW) begin
      anode_s = digit_en[idx_s] ? ~(4'b0001 << idx_s) : 4'b1111;
      seg_s   = hex_seg(nib_s);
      dp_n_s  = ~ddp_s[idx_s];
    end else begin
      anode_s = 4'b1111;
      seg_s   = 7'b1111111;
      dp_n_s  = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      timer_r  <= '0;
      idx_r    <= 2'd0;
      disp_r   <= 16'h0000;
      ddp_r    <= 4'b0000;
      pend_r   <= 16'h0000;
      pdp_r    <= 4'b0000;
      pfull_r  <= 1'b0;
      ready_r  <= 1'b1;
      anode_r  <= 4'b1111;
      seg_r    <= 7'b1111111;
      dp_n_r   <= 1'b1;
      fstart_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      idx_r    <= idx_s;
      disp_r   <= disp_s;
      ddp_r    <= ddp_s;
      pend_r   <= pend_s;
      pdp_r    <= pdp_s;
      pfull_r  <= pfull_s;
      ready_r  <= ~pfull_s;
      anode_r  <= anode_s;
      seg_r    <= seg_s;
      dp_n_r   <= dp_n_s;
      fstart_r <= load_s;
    end
  end

  assign value_ready = ready_r;
  assign digit_idx   = idx_r;
  assign anode       = anode_r;
  assign seg         = seg_r;
  assign dp_n        = dp_n_r;
  assign frame_start = fstart_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-position model of the display.
module tb_seg_scan_ctrl;

  localparam int DT    = 4;
  localparam int BT    = 2;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n, en, value_valid, value_ready;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en;
  logic [1:0]  digit_idx;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n, frame_start;

  int checks = 0;
  int errors = 0;

  // model: position inside the frame while running, plus the two buffers
  bit          m_run, m_pfull, m_fs, m_acc;
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp, m_den;

  seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .dp_in(dp_in), .digit_en(digit_en),
    .digit_idx(digit_idx), .anode(anode), .seg(seg), .dp_n(dp_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int h);
    string s;
    logic [6:0] m;
    case (h)
      0: s = "abcdef";   1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
      4: s = "bcfg";     5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
      8: s = "abcdefg";  9: s = "abcdfg";  10: s = "abcefg"; 11: s = "cdefg";
      12: s = "adef";    13: s = "bcdeg";  14: s = "adefg";  15: s = "aefg";
      default: s = "";
    endcase
    m = 7'h7F;
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit load;
    load  = 1'b0;
    m_acc = value_valid && !m_pfull;
    m_den = digit_en;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_disp = 0; m_ddp = 0;
      m_pend = 0; m_pdp = 0; m_pfull = 0; m_acc = 0;
    end else begin
      if (!en) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; load = 1;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        load  = (m_pos == 0);
      end
      if (load && m_pfull) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pfull = 0;
      end
      if (m_acc) begin
        m_pend = value; m_pdp = dp_in; m_pfull = 1;
      end
    end
    m_fs = load;
  endtask

  task automatic check_outputs();
    int slot;
    bit lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    slot = m_run ? m_pos / SLOT : 0;
    lit  = m_run && ((m_pos % SLOT) < DT);
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (lit) begin
      if (m_den[slot]) e_an = ~(4'b0001 << slot);
      e_seg = seg_of(int'((m_disp >> (4 * slot)) & 16'h000F));
      e_dp  = ~m_ddp[slot];
    end
    chk("digit_idx", 16'(digit_idx), 16'(slot));
    chk("anode", 16'(anode), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp_n", 16'(dp_n), 16'(e_dp));
    chk("frame_start", 16'(frame_start), 16'(m_fs));
    chk("value_ready", 16'(value_ready), 16'(!m_pfull));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] d);
    int n;
    value = v; dp_in = d; value_valid = 1'b1;
    n = 0; m_acc = 0;
    while (!m_acc && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (m_acc) else begin
      errors++;
      $error("FAIL offer_timeout: observed no transfer expected transfer within 200 cycles");
    end
    value_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; value_valid = 1'b0; value = 16'h0000;
    dp_in = 4'b0000; digit_en = 4'b1111;
    #2;
    run(2);
    chk("reset_anode", 16'(anode), 16'hF);
    chk("reset_ready", 16'(value_ready), 16'h1);

    // 1: value offered before enable, then a full scan
    rst_n = 1'b1;
    offer(16'h1234, 4'b0000);
    en = 1'b1;
    step();
    chk("first_frame_start", 16'(frame_start), 16'h1);
    chk("first_digit_4", 16'(seg), 16'(seg_of(4)));
    run(2 * FRAME);

    // 2: new value mid-frame, 3: second value while pending is full
    run(7);
    offer(16'hABCD, 4'b0000);
    offer(16'h5E70, 4'b1000);
    run(2 * FRAME);

    // 4: partial digit enable with a decimal point on digit 0
    digit_en = 4'b0101;
    offer(16'h9F08, 4'b0001);
    run(3 * FRAME);
    digit_en = 4'b1111;

    // 5: drop en while digit 2 is lit, then restart
    n = 0;
    while (!(m_run && m_pos >= 2 * SLOT && m_pos < 2 * SLOT + DT) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("reach_digit2", 16'(digit_idx), 16'h2);
    en = 1'b0;
    step();
    chk("dark_anode", 16'(anode), 16'hF);
    chk("dark_seg", 16'(seg), 16'h7F);
    en = 1'b1;
    step();
    chk("restart_fs", 16'(frame_start), 16'h1);
    chk("restart_idx", 16'(digit_idx), 16'h0);
    run(FRAME);

    // 6: reset pulse with pending full
    offer(16'h4321, 4'b1111);
    run(3);
    rst_n = 1'b0;
    step();
    chk("rst_ready", 16'(value_ready), 16'h1);
    chk("rst_seg", 16'(seg), 16'h7F);
    rst_n = 1'b1;
    step();
    chk("rst_disp_zero", 16'(seg), 16'(seg_of(0)));
    run(FRAME);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(0, 99) < 96);
      value_valid = ($urandom_range(0, 99) < 20);
      value       = 16'($urandom);
      dp_in       = 4'($urandom);
      if ($urandom_range(0, 99) < 3) digit_en = 4'($urandom);
      rst_n       = ($urandom_range(0, 999) >= 4);
      step();
    end
    rst_n = 1'b1; value_valid = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
